// File: rtl/scope_capture.sv
// Triggered double-banked waveform capture with a roll mode, serving scaled screen rows per column.
// Optional pre-trigger window: define SCOPE_PRETRIG_EN to keep DEPTH/2 samples before the trigger.
module scope_capture #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned DEPTH    = 600,
    parameter int unsigned Y_BOTTOM = 525,
    parameter int unsigned Y_SPAN   = 480
) (
    input  logic                                               clk,
    input  logic                                               rst,
    input  logic                                               sample_valid,
    input  logic [CHANNELS*DATA_W-1:0]                         sample,
    input  logic [7:0]                                         decim,
    input  logic [1:0]                                         mode,
    input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] trig_ch,
    input  logic [DATA_W-1:0]                                  trig_level,
    input  logic                                               trig_edge,
    input  logic                                               arm,
    input  logic                                               frame_end,
    input  logic [9:0]                                         rd_addr,
    output logic [CHANNELS*10-1:0]                             rd_row,
    output logic [2:0]                                         state
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned TW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int unsigned IW = $clog2(2 * DEPTH);
    localparam int unsigned PW = DATA_W + 10;
    localparam int unsigned SW = CHANNELS * DATA_W;
`ifdef SCOPE_PRETRIG_EN
    localparam int unsigned PRE = DEPTH / 2;
`else
    localparam int unsigned PRE = 0;
`endif
    localparam int unsigned POST_N = DEPTH - 1 - PRE;

    localparam logic [1:0] ModeNormal = 2'd1;
    localparam logic [1:0] ModeSingle = 2'd2;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StRoll  = 3'd1,
        StFill  = 3'd2,
        StArmed = 3'd3,
        StPost  = 3'd4,
        StDone  = 3'd5
    } state_e;

    // Without a pre-trigger window the fill phase has nothing to collect.
    localparam state_e StEntry = (PRE == 0) ? StArmed : StFill;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // (a + b) mod DEPTH for operands no larger than DEPTH.
    function automatic logic [AW-1:0] wrap_add(input logic [CW-1:0] a, input logic [CW-1:0] b);
        logic [CW:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= (CW + 1)'(DEPTH)) s = s - (CW + 1)'(DEPTH);
        return s[AW-1:0];
    endfunction

    state_e            state_q, state_d;
    logic [7:0]        dec_cnt_q, dec_cnt_d;
    logic              qv_q;
    logic [SW-1:0]     smp_q, smp_d;
    logic [1:0]        mode_q;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0] prev_q, prev_d;
    logic              prev_valid_q, prev_valid_d;
    logic [AW-1:0]     trig_ptr_q, trig_ptr_d;
    logic [AW-1:0]     disp_base_q, disp_base_d;
    logic              disp_bank_q, disp_bank_d;
    logic [1:0]        bank_valid_q, bank_valid_d;
    logic              swapped_q, swapped_d;

    logic              qual;
    logic              mode_roll;
    logic              mode_chg;
    logic              wr_bank;
    logic [DATA_W-1:0] cur;
    logic              hit;
    logic              mem_we;
    logic              done_entry;
    logic              restart;
    logic [IW-1:0]     wr_idx;

    logic              col_ok;
    logic [CW-1:0]     col;
    logic [AW-1:0]     rd_ptr;
    logic [IW-1:0]     rd_idx;
    logic [SW-1:0]     rd_word_q;
    logic              blank_q;
    logic [CHANNELS*10-1:0] rd_row_q, rd_row_d;

    logic [SW-1:0]     mem [2*DEPTH];

    assign qual      = sample_valid && (dec_cnt_q == 8'd0);
    assign mode_roll = (mode == 2'd0) || (mode == 2'd3);
    assign mode_chg  = (mode != mode_q);
    assign wr_bank   = (state_q == StRoll) ? disp_bank_q : ~disp_bank_q;
    assign wr_idx    = wr_bank ? IW'(wr_ptr_q) + IW'(DEPTH) : IW'(wr_ptr_q);
    assign state     = state_q;
    assign rd_row    = rd_row_q;

    always_comb begin
        dec_cnt_d = dec_cnt_q;
        if (sample_valid) dec_cnt_d = (dec_cnt_q == 8'd0) ? decim : dec_cnt_q - 8'd1;
        smp_d = qual ? sample : smp_q;
    end

    always_comb begin
        cur = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (trig_ch == TW'(c)) cur = smp_q[c*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        hit = 1'b0;
        if (prev_valid_q) begin
            if (trig_edge) hit = (prev_q >= trig_level) && (trig_level > cur);
            else           hit = (prev_q < trig_level) && (trig_level <= cur);
        end
    end

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        cnt_d        = cnt_q;
        prev_d       = prev_q;
        prev_valid_d = prev_valid_q;
        trig_ptr_d   = trig_ptr_q;
        disp_base_d  = disp_base_q;
        disp_bank_d  = disp_bank_q;
        bank_valid_d = bank_valid_q;
        swapped_d    = swapped_q;
        mem_we       = 1'b0;
        done_entry   = 1'b0;
        restart      = 1'b0;

        if (state_q == StIdle) begin
            state_d = mode_roll ? StRoll : StEntry;
        end else if (mode_chg) begin
            // Abandon the capture (including any in-flight sample); the display bank survives.
            state_d                    = mode_roll ? StRoll : StEntry;
            wr_ptr_d                   = '0;
            cnt_d                      = '0;
            prev_valid_d               = 1'b0;
            swapped_d                  = 1'b0;
            bank_valid_d[~disp_bank_q] = 1'b0;
        end else begin
            case (state_q)
                StRoll: begin
                    if (qv_q) begin
                        mem_we   = 1'b1;
                        wr_ptr_d = ptr_inc(wr_ptr_q);
                        if (cnt_q != CW'(DEPTH)) cnt_d = cnt_q + 1'b1;
                        if (cnt_q == CW'(DEPTH - 1)) bank_valid_d[disp_bank_q] = 1'b1;
                    end
                end
                StFill: begin
                    if (qv_q) begin
                        mem_we       = 1'b1;
                        wr_ptr_d     = ptr_inc(wr_ptr_q);
                        prev_d       = cur;
                        prev_valid_d = 1'b1;
                        cnt_d        = cnt_q + 1'b1;
                        if (cnt_q + 1'b1 == CW'(PRE)) begin
                            cnt_d   = '0;
                            state_d = StArmed;
                        end
                    end
                end
                StArmed: begin
                    if (qv_q) begin
                        mem_we       = 1'b1;
                        wr_ptr_d     = ptr_inc(wr_ptr_q);
                        prev_d       = cur;
                        prev_valid_d = 1'b1;
                        if (hit) begin
                            trig_ptr_d = wr_ptr_q;
                            cnt_d      = '0;
                            state_d    = StPost;
                        end
                    end
                end
                StPost: begin
                    if (qv_q) begin
                        mem_we   = 1'b1;
                        wr_ptr_d = ptr_inc(wr_ptr_q);
                        cnt_d    = cnt_q + 1'b1;
                        if (cnt_q + 1'b1 == CW'(POST_N)) begin
                            state_d               = StDone;
                            bank_valid_d[wr_bank] = 1'b1;
                            swapped_d             = 1'b0;
                            done_entry            = 1'b1;
                        end
                    end
                end
                StDone: begin
                    if (swapped_q && arm && (mode == ModeSingle)) restart = 1'b1;
                end
                default: state_d = StIdle;
            endcase

            // A frame_end landing on the completing cycle still swaps immediately.
            if (frame_end && (done_entry || ((state_q == StDone) && !swapped_q))) begin
                disp_bank_d               = ~disp_bank_q;
                bank_valid_d[disp_bank_q] = 1'b0;
                disp_base_d               = wrap_add({1'b0, trig_ptr_q}, CW'(DEPTH - PRE));
                if (mode == ModeNormal) restart = 1'b1;
                else                    swapped_d = 1'b1;
            end
        end

        if (restart) begin
            state_d      = StEntry;
            wr_ptr_d     = '0;
            cnt_d        = '0;
            prev_valid_d = 1'b0;
            swapped_d    = 1'b0;
        end
    end

    // Roll shows newest-first; triggered frames start at trigger minus the pre-trigger window.
    always_comb begin
        col_ok = 32'(rd_addr) < DEPTH;
        col    = col_ok ? CW'(rd_addr) : '0;
        if (state_q == StRoll) rd_ptr = wrap_add({1'b0, wr_ptr_q}, CW'(DEPTH - 1) - col);
        else                   rd_ptr = wrap_add({1'b0, disp_base_q}, col);
        rd_idx = disp_bank_q ? IW'(rd_ptr) + IW'(DEPTH) : IW'(rd_ptr);
    end

    always_comb begin
        rd_row_d = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            rd_row_d[c*10 +: 10] = blank_q ? 10'h3FF :
                10'(Y_BOTTOM) - 10'((PW'(rd_word_q[c*DATA_W +: DATA_W]) * PW'(Y_SPAN)) >> DATA_W);
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[wr_idx] <= smp_q;
        rd_word_q <= mem[rd_idx];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            dec_cnt_q    <= '0;
            qv_q         <= 1'b0;
            smp_q        <= '0;
            mode_q       <= '0;
            wr_ptr_q     <= '0;
            cnt_q        <= '0;
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
            trig_ptr_q   <= '0;
            disp_base_q  <= '0;
            disp_bank_q  <= 1'b0;
            bank_valid_q <= '0;
            swapped_q    <= 1'b0;
            blank_q      <= 1'b1;
            rd_row_q     <= '0;
        end else begin
            state_q      <= state_d;
            dec_cnt_q    <= dec_cnt_d;
            qv_q         <= qual;
            smp_q        <= smp_d;
            mode_q       <= mode;
            wr_ptr_q     <= wr_ptr_d;
            cnt_q        <= cnt_d;
            prev_q       <= prev_d;
            prev_valid_q <= prev_valid_d;
            trig_ptr_q   <= trig_ptr_d;
            disp_base_q  <= disp_base_d;
            disp_bank_q  <= disp_bank_d;
            bank_valid_q <= bank_valid_d;
            swapped_q    <= swapped_d;
            blank_q      <= !col_ok || !bank_valid_q[disp_bank_q];
            rd_row_q     <= rd_row_d;
        end
    end

endmodule
